alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU instance between two requesters (e.g. main pipeline and a
//  coprocessor/debug port) using a valid/ready request and response handshake.
//  Round-robin grant; operands are registered and held on the ALU for a
//  configurable settle time, then r/r2/z are captured into a response register.
//  One operation is in flight at a time. Illegal opcodes are flagged.
// PARAMETERS
//  ALU_WAIT  1   cycles operands are held on the ALU before capture (>=1; 0 illegal)
//  DATA_W    32  operand/result width
//  CTRL_W    6   ALU opcode width
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset       in   1       synchronous, active-high
//  req0_valid  in   1       requester 0 has an operation
//  req0_ready  out  1       requester 0 accepted this cycle (valid&ready)
//  req0_ctrl   in   CTRL_W  requester 0 opcode
//  req0_a      in   DATA_W  requester 0 operand a
//  req0_b      in   DATA_W  requester 0 operand b
//  req1_valid  in   1       requester 1 has an operation
//  req1_ready  out  1       requester 1 accepted this cycle
//  req1_ctrl   in   CTRL_W  requester 1 opcode
//  req1_a      in   DATA_W  requester 1 operand a
//  req1_b      in   DATA_W  requester 1 operand b
//  rsp_valid   out  1       response available
//  rsp_ready   in   1       consumer takes response
//  rsp_id      out  1       requester the response belongs to
//  rsp_r       out  DATA_W  result (ALU r)
//  rsp_r2      out  DATA_W  high result (ALU r2, multu high word)
//  rsp_z       out  1       zero flag
//  rsp_err     out  1       opcode illegal
//  alu_ctrl    out  CTRL_W  to ALU ctrl
//  alu_a       out  DATA_W  to ALU a
//  alu_b       out  DATA_W  to ALU b
//  alu_r       in   DATA_W  from ALU r
//  alu_r2      in   DATA_W  from ALU r2
//  alu_z       in   1       from ALU z
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE, last_id=1, all outputs/regs 0; readies forced 0 while reset=1.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant combinational. One valid -> that requester; both -> requester != last_id.
//   reqN_ready=1 only for granted N, only in IDLE. On accept edge: latch ctrl/a/b
//   into op regs, rsp_id=N, last_id=N, cnt=ALU_WAIT, go EXEC.
//  EXEC: alu_ctrl/a/b driven from op regs (stable); cnt decrements each cycle.
//   In cycle with cnt==1: capture alu_r/r2/z into rsp regs, go RESP.
//  RESP: rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready; then IDLE.
//   No new accept in same cycle as response handshake (readies 0 outside IDLE).
//  Latency: rsp_valid high ALU_WAIT+1 edges after accept edge; throughput
//   one op per ALU_WAIT+2 cycles minimum.
//  Legal opcodes: 0x00-0x04, 0x06-0x14. Otherwise rsp_err=1, rsp_r=0, rsp_r2=0,
//   rsp_z=1 (ALU outputs ignored); still occupies EXEC for ALU_WAIT cycles.
//  alu_* outputs hold last op regs in IDLE/RESP (0 after reset).
//  Requesters hold valid and payload until accepted; block samples only at accept.
//  Reset mid EXEC/RESP: op discarded, no response, last_id=1.
// TESTING (ALU_WAIT=1, real ALU attached)
//  req0 ctrl=0x02 a=5 b=7 -> accept T; rsp_valid at T+2, r=12 r2=0 z=0 id=0 err=0.
//  Both valid after reset: req0 ctrl=0x06 a=3 b=3, req1 ctrl=0x13 a=b=0x10000 ->
//   rsp id=0 r=0 z=1; then id=1 r=0 r2=1 z=1.
//  Both held valid for 4 ops -> rsp_id sequence 0,1,0,1; no starvation.
//  rsp_ready low 5 cycles in RESP -> rsp_* stable, both readies 0, busy=1.
//  ctrl=0x05 and ctrl=0x20 -> err=1 r=0 r2=0 z=1; next legal op unaffected.
//  reset asserted during EXEC -> no rsp_valid; next req1 op served normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, response and ALU-side signals of the shared ALU arbiter
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
);
    logic              req0_valid;
    logic              req0_ready;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_r;
    logic [DATA_W-1:0] rsp_r2;
    logic              rsp_z;
    logic              rsp_err;

    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] alu_r2;
    logic              alu_z;

    logic              busy;

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output rsp_ready,
        output alu_r, alu_r2, alu_z,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_r2, rsp_z, rsp_err,
        input  alu_ctrl, alu_a, alu_b,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  rsp_ready,
        input  alu_r, alu_r2, alu_z,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_r2, rsp_z, rsp_err,
        output alu_ctrl, alu_a, alu_b,
        output busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
// One op in flight: operands held on the ALU for ALU_WAIT cycles, result registered.
module alu_arbiter #(
    parameter int ALU_WAIT = 1,
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    localparam int CNT_W = (ALU_WAIT < 2) ? 1 : $clog2(ALU_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ALU_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_id;
    logic [CTRL_W-1:0] r_op_ctrl;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_r;
    logic [DATA_W-1:0] r_rsp_r2;
    logic              r_rsp_z;
    logic              r_rsp_err;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_acc0;
    logic w_acc1;
    logic w_legal;

    assign w_idle = (r_state == S_IDLE) && !reset;

    // On contention the requester that was not served last wins.
    assign w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last_id);
    assign w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_id);
    assign w_acc0 = w_idle && w_gnt0;
    assign w_acc1 = w_idle && w_gnt1;

    // Opcode 0x05 and everything above 0x14 have no ALU function.
    assign w_legal = (r_op_ctrl <= CTRL_W'(4)) ||
                     ((r_op_ctrl >= CTRL_W'(6)) && (r_op_ctrl <= CTRL_W'(20)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last_id <= 1'b1;
            r_op_ctrl <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_rsp_id  <= 1'b0;
            r_rsp_r   <= '0;
            r_rsp_r2  <= '0;
            r_rsp_z   <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_op_ctrl <= w_acc1 ? bus.req1_ctrl : bus.req0_ctrl;
                        r_op_a    <= w_acc1 ? bus.req1_a    : bus.req0_a;
                        r_op_b    <= w_acc1 ? bus.req1_b    : bus.req0_b;
                        r_rsp_id  <= w_acc1;
                        r_last_id <= w_acc1;
                        r_cnt     <= WAIT_INIT;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        if (w_legal) begin
                            r_rsp_r   <= bus.alu_r;
                            r_rsp_r2  <= bus.alu_r2;
                            r_rsp_z   <= bus.alu_z;
                            r_rsp_err <= 1'b0;
                        end else begin
                            r_rsp_r   <= '0;
                            r_rsp_r2  <= '0;
                            r_rsp_z   <= 1'b1;
                            r_rsp_err <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = w_acc0;
    assign bus.req1_ready = w_acc1;

    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_r      = r_rsp_r;
    assign bus.rsp_r2     = r_rsp_r2;
    assign bus.rsp_z      = r_rsp_z;
    assign bus.rsp_err    = r_rsp_err;

    assign bus.alu_ctrl   = r_op_ctrl;
    assign bus.alu_a      = r_op_a;
    assign bus.alu_b      = r_op_b;

    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vectors for alu_arbiter with a small ALU attached
module tb_alu_arbiter;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    alu_arbiter_if #(.DATA_W(32), .CTRL_W(6)) bus ();

    alu_arbiter #(.ALU_WAIT(1), .DATA_W(32), .CTRL_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // add, sub and 64-bit unsigned multiply are the opcodes the vectors use
    logic [31:0] w_alu_r;
    logic [31:0] w_alu_r2;
    always_comb begin
        w_alu_r  = '0;
        w_alu_r2 = '0;
        case (bus.alu_ctrl)
            6'h02:   w_alu_r = bus.alu_a + bus.alu_b;
            6'h06:   w_alu_r = bus.alu_a - bus.alu_b;
            6'h13:   {w_alu_r2, w_alu_r} = 64'(bus.alu_a) * 64'(bus.alu_b);
            default: w_alu_r = bus.alu_a ^ bus.alu_b;
        endcase
    end
    assign bus.alu_r  = w_alu_r;
    assign bus.alu_r2 = w_alu_r2;
    assign bus.alu_z  = (w_alu_r == 32'd0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic hold_valid;

    // one cycle; accepted requests are withdrawn unless hold_valid is set
    task automatic tick();
        logic a0;
        logic a1;
        @(negedge clk);
        a0 = bus.req0_valid && bus.req0_ready;
        a1 = bus.req1_valid && bus.req1_ready;
        @(posedge clk);
        #1;
        if (a0 && !hold_valid) bus.req0_valid = 1'b0;
        if (a1 && !hold_valid) bus.req1_valid = 1'b0;
    endtask

    task automatic issue(input int n, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_rsp_seen"}, 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic take_rsp(input string tag, input logic id, input logic [31:0] r,
                            input logic [31:0] r2, input logic z, input logic err);
        wait_rsp(tag);
        check({tag, "_id"},  64'(bus.rsp_id),  64'(id));
        check({tag, "_r"},   64'(bus.rsp_r),   64'(r));
        check({tag, "_r2"},  64'(bus.rsp_r2),  64'(r2));
        check({tag, "_z"},   64'(bus.rsp_z),   64'(z));
        check({tag, "_err"}, 64'(bus.rsp_err), 64'(err));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    logic [31:0] ids;
    logic [31:0] held_r;

    initial begin
        n_total = 0;
        n_bad = 0;
        hold_valid = 1'b0;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_ctrl = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_ctrl = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready = 1'b0;

        // reset: readies forced low even with a pending request
        tick(); tick();
        issue(0, 6'h02, 32'd1, 32'd1);
        #1;
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        tick();
        check("rst_busy",   64'(bus.busy),       64'd0);
        check("rst_rspv",   64'(bus.rsp_valid),  64'd0);
        check("rst_alu_a",  64'(bus.alu_a),      64'd0);
        check("rst_rsp_r",  64'(bus.rsp_r),      64'd0);
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // single add, latency check
        issue(0, 6'h02, 32'd5, 32'd7);
        #1;
        check("add_ready0", 64'(bus.req0_ready), 64'd1);
        tick();
        check("add_busy",   64'(bus.busy),      64'd1);
        check("add_rspv_e", 64'(bus.rsp_valid), 64'd0);
        check("add_alu_a",  64'(bus.alu_a),     64'd5);
        tick();
        check("add_rspv_t2", 64'(bus.rsp_valid), 64'd1);
        take_rsp("add", 1'b0, 32'd12, 32'd0, 1'b0, 1'b0);
        check("add_idle", 64'(bus.busy), 64'd0);

        // contention after reset goes to requester 0 (last_id resets to 1)
        reset = 1'b1; tick(); reset = 1'b0;
        issue(0, 6'h06, 32'd3, 32'd3);
        issue(1, 6'h13, 32'h10000, 32'h10000);
        #1;
        check("both_r0", 64'({bus.req1_ready, bus.req0_ready}), 64'b01);
        tick();
        take_rsp("sub", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        take_rsp("mul", 1'b1, 32'd0, 32'd1, 1'b1, 1'b0);

        // both held valid: alternation 0,1,0,1
        hold_valid = 1'b1;
        issue(0, 6'h02, 32'd1, 32'd1);
        issue(1, 6'h02, 32'd2, 32'd2);
        ids = '0;
        for (int i = 0; i < 4; i++) begin
            wait_rsp("rr");
            ids[i] = bus.rsp_id;
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
        hold_valid = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("rr_ids", 64'(ids[3:0]), 64'b1010);
        tick(); tick();

        // response back-pressure: everything stable, no accepts
        issue(1, 6'h02, 32'd100, 32'd23);
        tick();
        wait_rsp("stall");
        held_r = bus.rsp_r;
        check("stall_r", 64'(held_r), 64'd123);
        issue(0, 6'h02, 32'd9, 32'd9);
        issue(1, 6'h02, 32'd8, 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_rspv",  64'(bus.rsp_valid), 64'd1);
            check("stall_hold",  64'(bus.rsp_r),     64'd123);
            check("stall_rdys",  64'({bus.req1_ready, bus.req0_ready}), 64'd0);
            check("stall_busy",  64'(bus.busy),      64'd1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        take_rsp("stall", 1'b1, 32'd123, 32'd0, 1'b0, 1'b0);

        // illegal opcodes, then a legal one
        issue(0, 6'h05, 32'd9, 32'd9);
        tick();
        take_rsp("ill05", 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        issue(1, 6'h20, 32'd4, 32'd1);
        tick();
        take_rsp("ill20", 1'b1, 32'd0, 32'd0, 1'b1, 1'b1);
        issue(0, 6'h02, 32'd1, 32'd2);
        tick();
        take_rsp("post_ill", 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

        // reset during EXEC discards the op
        issue(0, 6'h02, 32'd40, 32'd2);
        tick();
        check("rexec_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rexec_norsp", 64'({bus.busy, bus.rsp_valid}), 64'd0);
        end
        issue(1, 6'h06, 32'd10, 32'd4);
        tick();
        take_rsp("after_rst", 1'b1, 32'd6, 32'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
